// File: rtl/alap_arbiter.sv
// Round-robin front end that shares one alap engine between NREQ requesters.
// Launches the winner's operands, waits for done or timeout, then acks the owner.
module alap_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*WIDTH-1:0]      req_in0,
   input  logic [NREQ*WIDTH-1:0]      req_in1,
   output logic [NREQ-1:0]            ack,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       rsp_err,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic                       busy,
   output logic [2:0]                 CS,
   output logic                       alap_go,
   output logic [WIDTH-1:0]           alap_in0,
   output logic [WIDTH-1:0]           alap_in1,
   output logic                       alap_abort,
   input  logic [WIDTH-1:0]           alap_out,
   input  logic                       alap_done
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      RESP   = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    grant_q, grant_d;
   logic [WIDTH-1:0]  in0_q, in0_d;
   logic [WIDTH-1:0]  in1_q, in1_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              err_q, err_d;
   logic              go_q, go_d;
   logic              abort_q, abort_d;

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [IDW:0]      start;
   logic [IDW-1:0]    off;
   logic [IDW+1:0]    sum;
   logic [IDW-1:0]    win_idx;
   logic              win_vld;
   logic [WIDTH-1:0]  win_in0;
   logic [WIDTH-1:0]  win_in1;
   logic              timeout;

   // Rotate so the slot after the last winner sits at bit 0, then find first set.
   always_comb begin
      req_dbl = {req, req};
      start   = {1'b0, ptr_q} + (IDW+1)'(1);
      req_rot = req_dbl[start +: NREQ];
      off     = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_rot[i]) off = IDW'(i);
      end
      sum = {1'b0, start} + {2'b00, off};
      if (sum >= (IDW+2)'(NREQ)) sum = sum - (IDW+2)'(NREQ);
      win_idx = sum[IDW-1:0];
      win_vld = |req;
      win_in0 = '0;
      win_in1 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == win_idx) begin
            win_in0 = req_in0[i*WIDTH +: WIDTH];
            win_in1 = req_in1[i*WIDTH +: WIDTH];
         end
      end
   end

   assign timeout = (cnt_q == CW'(TIMEOUT-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NREQ-1);
         grant_q <= '0;
         in0_q   <= '0;
         in1_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         go_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         go_q    <= go_d;
         abort_q <= abort_d;
      end
   end

   // A done seen in IDLE is stale from the previous owner, so it blocks a grant.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_vld && !alap_done) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (alap_done || timeout) state_d = RESP;
         RESP:    state_d = DRAIN;
         DRAIN:   if (!alap_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pulses are computed one cycle early so they leave the block registered.
   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      in0_d   = in0_q;
      in1_d   = in1_q;
      cnt_d   = cnt_q;
      data_d  = '0;
      err_d   = 1'b0;
      abort_d = 1'b0;
      ack_d   = '0;
      go_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (state_d == LAUNCH) begin
               grant_d = win_idx;
               ptr_d   = win_idx;
               in0_d   = win_in0;
               in1_d   = win_in1;
               go_d    = 1'b1;
            end
         end
         LAUNCH: cnt_d = '0;
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (alap_done) begin
               data_d = alap_out;
               ack_d  = NREQ'(1) << grant_q;
            end else if (timeout) begin
               err_d   = 1'b1;
               abort_d = 1'b1;
               ack_d   = NREQ'(1) << grant_q;
            end
         end
         default: ;
      endcase
   end

   assign ack        = ack_q;
   assign rsp_data   = data_q;
   assign rsp_err    = err_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q != IDLE);
   assign CS         = state_q;
   assign alap_go    = go_q;
   assign alap_in0   = in0_q;
   assign alap_in1   = in1_q;
   assign alap_abort = abort_q;

endmodule
